// File: rtl/shift_register_universal.sv
// Universal shift register: hold, parallel load, logical/arithmetic shifts,
// rotates and synchronous clear, chosen per cycle by a 3-bit mode code.
// A saturating shift counter and a one-cycle done pulse support use as a
// serializer/deserializer front end (load, shift WIDTH times, done).
module shift_register_universal #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] Din,
    input  logic             Din_serie_l,
    input  logic             Din_serie_r,
    output logic [WIDTH-1:0] Dout,
    output logic             Sout_l,
    output logic             Sout_r,
    output logic [CW-1:0]    shift_cnt,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] dout_reg, dout_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             done_reg, done_next;
    logic             is_shift;

    // Next-state decode: data path per mode, then the shared counter/done update
    always_comb begin
        dout_next = dout_reg;
        cnt_next  = cnt_reg;
        done_next = 1'b0;
        is_shift  = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: dout_next = dout_reg;
                MODE_LOAD: begin
                    dout_next = Din;
                    cnt_next  = '0;
                end
                MODE_SHL: begin
                    dout_next = {dout_reg[WIDTH-2:0], Din_serie_l};
                    is_shift  = 1'b1;
                end
                MODE_SHR: begin
                    dout_next = {Din_serie_r, dout_reg[WIDTH-1:1]};
                    is_shift  = 1'b1;
                end
                MODE_ROL: begin
                    dout_next = {dout_reg[WIDTH-2:0], dout_reg[WIDTH-1]};
                    is_shift  = 1'b1;
                end
                MODE_ROR: begin
                    dout_next = {dout_reg[0], dout_reg[WIDTH-1:1]};
                    is_shift  = 1'b1;
                end
                MODE_ASR: begin
                    dout_next = {dout_reg[WIDTH-1], dout_reg[WIDTH-1:1]};
                    is_shift  = 1'b1;
                end
                MODE_CLR: begin
                    dout_next = '0;
                    cnt_next  = '0;
                end
                default: dout_next = dout_reg;
            endcase
            // Counter saturates at WIDTH; done marks only the WIDTH-1 -> WIDTH step,
            // so a saturated counter never re-triggers it.
            if (is_shift && (cnt_reg != CNT_FULL)) begin
                cnt_next  = cnt_reg + 1'b1;
                done_next = (cnt_reg == CNT_LAST);
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_reg <= '0;
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            dout_reg <= dout_next;
            cnt_reg  <= cnt_next;
            done_reg <= done_next;
        end
    end

    assign Dout      = dout_reg;
    assign Sout_l    = dout_reg[WIDTH-1];
    assign Sout_r    = dout_reg[0];
    assign shift_cnt = cnt_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed testbench for shift_register_universal (WIDTH=8 and WIDTH=4 instances).
module tb_shift_register_universal;

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] SHL  = 3'b010;
    localparam logic [2:0] SHR  = 3'b011;
    localparam logic [2:0] ROL  = 3'b100;
    localparam logic [2:0] ROR  = 3'b101;
    localparam logic [2:0] ASR  = 3'b110;
    localparam logic [2:0] CLR  = 3'b111;

    logic       clk = 1'b0;
    logic       reset;
    // WIDTH=8 instance
    logic       en;
    logic [2:0] mode;
    logic [7:0] din;
    logic       sl, sr;
    logic [7:0] dout;
    logic       sout_l, sout_r;
    logic [3:0] cnt;
    logic       done;
    // WIDTH=4 instance
    logic       en4;
    logic [2:0] mode4;
    logic [3:0] din4;
    logic       sl4, sr4;
    logic [3:0] dout4;
    logic       sout_l4, sout_r4;
    logic [2:0] cnt4;
    logic       done4;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    shift_register_universal #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .Din(din),
        .Din_serie_l(sl), .Din_serie_r(sr), .Dout(dout),
        .Sout_l(sout_l), .Sout_r(sout_r), .shift_cnt(cnt), .done(done)
    );

    shift_register_universal #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .en(en4), .mode(mode4), .Din(din4),
        .Din_serie_l(sl4), .Din_serie_r(sr4), .Dout(dout4),
        .Sout_l(sout_l4), .Sout_r(sout_r4), .shift_cnt(cnt4), .done(done4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] m, input logic [7:0] d, input logic s_l, input logic s_r);
        mode = m; din = d; sl = s_l; sr = s_r;
        tick();
    endtask

    task automatic op4(input logic [2:0] m, input logic [3:0] d, input logic s_l);
        mode4 = m; din4 = d; sl4 = s_l; sr4 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tests_run++;
        if ({dout, cnt, done} !== 13'h0) begin
            tests_failed++;
            $display("FAIL reset_initial: got dout=%h cnt=%0d done=%b, expected 00/0/0", dout, cnt, done);
        end
        reset = 1'b1;
        op(LOAD, 8'hB4, 1'b0, 1'b0);
        op(SHL, 8'h00, 1'b1, 1'b0);
        op(SHL, 8'h00, 1'b0, 1'b0);
        op(SHL, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if (dout !== 8'hA5 || cnt !== 4'd3) begin
            tests_failed++;
            $display("FAIL reset_setup: got dout=%h cnt=%0d, expected A5/3", dout, cnt);
        end
        mode = HOLD;
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (dout !== 8'h00 || cnt !== 4'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: got dout=%h cnt=%0d done=%b, expected 00/0/0", dout, cnt, done);
        end
        #1 reset = 1'b1;
        op(HOLD, 8'hFF, 1'b1, 1'b1);
        tests_run++;
        if (dout !== 8'h00 || cnt !== 4'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_hold: got dout=%h cnt=%0d done=%b, expected 00/0/0", dout, cnt, done);
        end
    endtask

    task automatic test_load_shift();
        logic [7:0] exp_bits;
        exp_bits = 8'b1011_0100;
        op(LOAD, 8'hB4, 1'b0, 1'b0);
        tests_run++;
        if (dout !== 8'hB4 || cnt !== 4'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL load: got dout=%h cnt=%0d done=%b, expected B4/0/0", dout, cnt, done);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (sout_l !== exp_bits[7-i]) begin
                tests_failed++;
                $display("FAIL tx_bit%0d: got sout_l=%b expected %b", i, sout_l, exp_bits[7-i]);
            end
            op(SHL, 8'h00, 1'b1, 1'b0);
            tests_run++;
            if (cnt !== 4'(i + 1) || done !== (i == 7)) begin
                tests_failed++;
                $display("FAIL tx_shift%0d: got cnt=%0d done=%b expected %0d/%b", i + 1, cnt, done, i + 1, (i == 7));
            end
        end
        tests_run++;
        if (dout !== 8'hFF) begin
            tests_failed++;
            $display("FAIL tx_final: got dout=%h expected FF", dout);
        end
        op(HOLD, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (done !== 1'b0 || cnt !== 4'd8) begin
            tests_failed++;
            $display("FAIL tx_after_done: got cnt=%0d done=%b expected 8/0", cnt, done);
        end
    endtask

    task automatic test_rotate_asr();
        logic [2:0] rm[7];
        logic       rsr[7];
        logic [7:0] rexp[7];
        rm = '{LOAD, ROL, ROR, ASR, ASR, SHR, SHR};
        rsr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        rexp = '{8'h81, 8'h03, 8'h81, 8'hC0, 8'hE0, 8'h70, 8'hB8};
        for (int i = 0; i < 7; i++) begin
            op(rm[i], 8'h81, 1'b0, rsr[i]);
            tests_run++;
            if (dout !== rexp[i]) begin
                tests_failed++;
                $display("FAIL rot_step%0d: got dout=%h expected %h", i, dout, rexp[i]);
            end
        end
        tests_run++;
        if (sout_l !== 1'b1 || sout_r !== 1'b0 || cnt !== 4'd6) begin
            tests_failed++;
            $display("FAIL rot_serial_out: got sout_l=%b sout_r=%b cnt=%0d expected 1/0/6", sout_l, sout_r, cnt);
        end
    endtask

    task automatic test_saturation();
        int dones;
        dones = 0;
        op(LOAD, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            op(SHL, 8'h00, 1'b0, 1'b0);
            if (done === 1'b1) dones++;
            tests_run++;
            if (cnt !== 4'((i > 8) ? 8 : i) || done !== (i == 8)) begin
                tests_failed++;
                $display("FAIL sat_shift%0d: got cnt=%0d done=%b expected %0d/%b", i, cnt, done, (i > 8) ? 8 : i, (i == 8));
            end
        end
        tests_run++;
        if (dones !== 1) begin
            tests_failed++;
            $display("FAIL sat_done_count: got %0d pulses expected 1", dones);
        end
    endtask

    task automatic test_enable();
        op(LOAD, 8'h3C, 1'b0, 1'b0);
        op(SHL, 8'h00, 1'b0, 1'b0);
        op(SHL, 8'h00, 1'b0, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op(SHL, 8'hFF, 1'b1, 1'b1);
            tests_run++;
            if (dout !== 8'hF0 || cnt !== 4'd2 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL en_hold%0d: got dout=%h cnt=%0d done=%b expected F0/2/0", i, dout, cnt, done);
            end
        end
        en = 1'b1;
        op(SHL, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (dout !== 8'hE0 || cnt !== 4'd3) begin
            tests_failed++;
            $display("FAIL en_resume: got dout=%h cnt=%0d expected E0/3", dout, cnt);
        end
        for (int i = 0; i < 5; i++) op(SHL, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (cnt !== 4'd8 || done !== 1'b1 || dout !== 8'h00) begin
            tests_failed++;
            $display("FAIL en_reach_done: got dout=%h cnt=%0d done=%b expected 00/8/1", dout, cnt, done);
        end
        en = 1'b0;
        op(SHL, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if (done !== 1'b0 || cnt !== 4'd8 || dout !== 8'h00) begin
            tests_failed++;
            $display("FAIL en_done_forced: got dout=%h cnt=%0d done=%b expected 00/8/0", dout, cnt, done);
        end
        en = 1'b1;
    endtask

    task automatic test_clear_reload();
        logic [7:0] rx;
        rx = 8'b1100_1010;
        op(LOAD, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) op(SHL, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (dout !== 8'hE0 || cnt !== 4'd5) begin
            tests_failed++;
            $display("FAIL clr_setup: got dout=%h cnt=%0d expected E0/5", dout, cnt);
        end
        op(CLR, 8'hAA, 1'b1, 1'b1);
        tests_run++;
        if (dout !== 8'h00 || cnt !== 4'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr: got dout=%h cnt=%0d done=%b expected 00/0/0", dout, cnt, done);
        end
        for (int i = 0; i < 8; i++) begin
            op(SHL, 8'h00, rx[7-i], 1'b0);
            tests_run++;
            if (done !== (i == 7)) begin
                tests_failed++;
                $display("FAIL rx_shift%0d: got done=%b expected %b", i + 1, done, (i == 7));
            end
        end
        tests_run++;
        if (dout !== 8'hCA || cnt !== 4'd8) begin
            tests_failed++;
            $display("FAIL rx_word: got dout=%h cnt=%0d expected CA/8", dout, cnt);
        end
        op(LOAD, 8'h55, 1'b0, 1'b0);
        tests_run++;
        if (dout !== 8'h55 || cnt !== 4'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reload_after_done: got dout=%h cnt=%0d done=%b expected 55/0/0", dout, cnt, done);
        end
    endtask

    task automatic test_width4();
        logic [3:0] bits;
        bits = 4'b1001;
        en = 1'b0;
        en4 = 1'b1;
        op4(LOAD, 4'h9, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (sout_l4 !== bits[3-i]) begin
                tests_failed++;
                $display("FAIL w4_bit%0d: got sout_l=%b expected %b", i, sout_l4, bits[3-i]);
            end
            op4(SHL, 4'h0, 1'b0);
            tests_run++;
            if (cnt4 !== 3'(i + 1) || done4 !== (i == 3)) begin
                tests_failed++;
                $display("FAIL w4_shift%0d: got cnt=%0d done=%b expected %0d/%b", i + 1, cnt4, done4, i + 1, (i == 3));
            end
        end
        op4(SHL, 4'h0, 1'b1);
        tests_run++;
        if (cnt4 !== 3'd4 || done4 !== 1'b0 || dout4 !== 4'h1) begin
            tests_failed++;
            $display("FAIL w4_saturate: got dout=%h cnt=%0d done=%b expected 1/4/0", dout4, cnt4, done4);
        end
        op4(LOAD, 4'h8, 1'b0);
        op4(ASR, 4'h0, 1'b0);
        tests_run++;
        if (dout4 !== 4'hC || sout_r4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL w4_asr: got dout=%h sout_r=%b expected C/0", dout4, sout_r4);
        end
        en4 = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        en = 1'b1; mode = HOLD; din = '0; sl = 1'b0; sr = 1'b0;
        en4 = 1'b0; mode4 = HOLD; din4 = '0; sl4 = 1'b0; sr4 = 1'b0;
        #1;
        test_reset();
        test_load_shift();
        test_rotate_asr();
        test_saturation();
        test_enable();
        test_clear_reload();
        test_width4();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
